// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair.
// Holds the FSM state encoding, the frame width and the clocks-per-bit
// derivation, so both ends of the link compute the same bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int DATA_BITS = 8;

  // Clocks per bit. Integer division truncates; the resulting rate error
  // is small compared with the receiver's mid-bit sampling margin.
  function automatic int calc_bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
// Two-flop synchroniser brings the asynchronous rx pin into the clk domain,
// and a third flop delays it once more so a high-to-low transition can be
// detected.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high
//   rx        in   raw serial line, idle high
//   rx_s      out  synchronised line
//   fall_edge out  high for one cycle when rx_s goes from 1 to 0
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic rx_meta;
  logic rx_d;

  // All three flops reset to the idle line level so that leaving reset
  // never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Edge needs the previous sample high, so a held-low line cannot retrigger.
  assign fall_edge = rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Validates the start bit at mid-bit, samples 8 data bits LSB-first one bit
// period apart, checks the stop bit, and presents each good byte on a
// valid/ack hold interface with framing-error and overrun reporting.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high
//   rx            in   raw serial line, idle high
//   rx_data       out  last good byte
//   rx_valid      out  rx_data holds an unacknowledged byte
//   rx_ack        in   consumer accepts rx_data
//   framing_error out  one-cycle pulse when the stop bit is sampled low
//   overrun       out  sticky, a byte was overwritten before ack
//   rx_busy       out  receiver is inside a frame
//   LED           out  copy of rx_data for board debug
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_error,
  output logic       overrun,
  output logic       rx_busy,
  output logic [7:0] LED
);

  localparam int BIT_PERIOD  = calc_bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;

  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [15:0]          clk_count;
  logic [2:0]           bit_index;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

  // Receive FSM plus the output registers. The handshake clear is written
  // first so that a byte landing in the same cycle as rx_ack overrides it:
  // the new byte stays valid and no overrun is raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clk_count     <= 16'd0;
      bit_index     <= 3'd0;
      shift_reg     <= '0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= 1'b0;

      if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_count <= 16'd0;
          bit_index <= 3'd0;
          if (fall_edge) begin
            state <= START;
          end
        end

        START: begin
          if (clk_count == HALF_LAST) begin
            clk_count <= 16'd0;
            state     <= rx_s ? IDLE : DATA;
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        DATA: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= 16'd0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_index <= bit_index + 3'd1;
            if (bit_index == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        STOP: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= 16'd0;
            state     <= IDLE;
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            clk_count <= clk_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);
  assign LED     = rx_data;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
// Frames are driven on the falling clock edge and outputs are sampled on the
// falling edge, away from the active rising edge.
module tb_uart_rx;

  localparam int CF = 1_600_000;
  localparam int BR = 100_000;
  localparam int BP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       rx_busy;
  logic [7:0] LED;

  int checks   = 0;
  int failures = 0;
  int fe_total = 0;
  int fe_base;
  int rise;

  uart_rx #(
    .CLOCK_FREQ (CF),
    .BAUD_RATE  (BR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .framing_error (framing_error),
    .overrun       (overrun),
    .rx_busy       (rx_busy),
    .LED           (LED)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Running count of cycles with framing_error high.
  always @(negedge clk) begin
    if (framing_error) fe_total++;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Hold the line at a level for n clocks.
  task automatic idleCycles(input int n, input logic level);
    rx = level;
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset for two clocks and release it.
  task automatic pulseReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drive one 10-bit frame. cyc counts rising edges since the start bit was
  // driven; rise_cyc reports the first cycle rx_valid was seen rising, and
  // ack_at (if >0) pulses rx_ack so it is sampled on rising edge ack_at+1.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int ack_at, output int rise_cyc);
    logic [9:0] frame;
    logic       prev;
    int         cyc;
    frame    = {stop_bit, data, 1'b0};
    prev     = rx_valid;
    cyc      = 0;
    rise_cyc = -1;
    for (int b = 0; b < 10; b++) begin
      rx = frame[b];
      for (int c = 0; c < BP; c++) begin
        @(negedge clk);
        cyc++;
        if (rx_valid && !prev && rise_cyc < 0) rise_cyc = cyc;
        prev = rx_valid;
        if (cyc == ack_at) rx_ack = 1'b1;
        else if (cyc == ack_at + 1) rx_ack = 1'b0;
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'h00);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("reset_led", {24'd0, LED}, 32'h00);

    reset = 1'b0;
    idleCycles(20, 1'b1);

    // Good frame 0xA5. Start driven before rising edge 1; START entered on
    // edge 3; stop sampled on edge 155, so rx_valid is first seen at 155.
    fe_base = fe_total;
    applyStimulus(8'hA5, 1'b1, -1, rise);
    checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
    checkOutput("a5_led", {24'd0, LED}, 32'hA5);
    checkOutput("a5_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("a5_valid_cycle", rise, 32'd155);
    checkOutput("a5_no_fe", fe_total - fe_base, 32'd0);
    checkOutput("a5_busy_low", {31'd0, rx_busy}, 32'd0);

    // Short low glitch: rejected at mid start bit.
    pulseReset();
    idleCycles(10, 1'b1);
    fe_base = fe_total;
    idleCycles(4, 1'b0);
    idleCycles(6, 1'b1);
    checkOutput("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
    idleCycles(200, 1'b1);
    checkOutput("glitch_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("glitch_no_fe", fe_total - fe_base, 32'd0);
    checkOutput("glitch_busy", {31'd0, rx_busy}, 32'd0);

    // 0x3C with a low stop bit, then a held-low break.
    fe_base = fe_total;
    applyStimulus(8'h3C, 1'b0, -1, rise);
    idleCycles(64, 1'b0);
    checkOutput("fe_pulse_count", fe_total - fe_base, 32'd1);
    checkOutput("fe_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("fe_data", {24'd0, rx_data}, 32'h00);
    checkOutput("break_no_retrigger", {31'd0, rx_busy}, 32'd0);
    idleCycles(16, 1'b1);
    applyStimulus(8'h3C, 1'b1, -1, rise);
    checkOutput("fe_recover_data", {24'd0, rx_data}, 32'h3C);
    checkOutput("fe_recover_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("fe_recover_no_fe", fe_total - fe_base, 32'd1);

    // Consume 0x3C.
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    checkOutput("ack_3c_valid", {31'd0, rx_valid}, 32'd0);

    // Back-to-back 0x11, 0x22 with no ack: overrun.
    applyStimulus(8'h11, 1'b1, -1, rise);
    checkOutput("b2b_first_data", {24'd0, rx_data}, 32'h11);
    checkOutput("b2b_first_no_ovr", {31'd0, overrun}, 32'd0);
    applyStimulus(8'h22, 1'b1, -1, rise);
    checkOutput("b2b_data", {24'd0, rx_data}, 32'h22);
    checkOutput("b2b_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("b2b_overrun", {31'd0, overrun}, 32'd1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    checkOutput("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("ack_clears_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("ack_keeps_data", {24'd0, rx_data}, 32'h22);
    @(negedge clk);

    // Ack in the exact cycle 0x22 lands: new byte wins, no overrun.
    applyStimulus(8'h11, 1'b1, -1, rise);
    applyStimulus(8'h22, 1'b1, 154, rise);
    checkOutput("same_cycle_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("same_cycle_data", {24'd0, rx_data}, 32'h22);
    checkOutput("same_cycle_overrun", {31'd0, overrun}, 32'd0);

    // Reset during data bit 4 of 0xFF.
    idleCycles(16, 1'b1);
    idleCycles(BP, 1'b0);
    idleCycles(4 * BP + 8, 1'b1);
    checkOutput("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midframe_reset_data", {24'd0, rx_data}, 32'h00);
    checkOutput("midframe_reset_valid", {31'd0, rx_valid}, 32'd0);
    reset = 1'b0;
    idleCycles(32, 1'b1);
    checkOutput("midframe_reset_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("midframe_reset_led", {24'd0, LED}, 32'h00);
    fe_base = fe_total;
    applyStimulus(8'h5A, 1'b1, -1, rise);
    checkOutput("post_reset_data", {24'd0, rx_data}, 32'h5A);
    checkOutput("post_reset_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("post_reset_no_fe", fe_total - fe_base, 32'd0);
    checkOutput("post_reset_overrun", {31'd0, overrun}, 32'd0);

    idleCycles(10, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
